// File: rtl/probe_cmd_pkg.sv
// Shared opcode constants, FSM state type and command-shape decoder for probe command arbitration.
// PCA_RSP_TIMEOUT_EN adds the RERR state used after a response timeout.
package probe_cmd_pkg;

  localparam logic [7:0] CMD_RD_A_LO = 8'd2;
  localparam logic [7:0] CMD_RD_A_HI = 8'd9;
  localparam logic [7:0] CMD_WR_A_LO = 8'd10;
  localparam logic [7:0] CMD_WR_A_HI = 8'd13;
  localparam logic [7:0] CMD_RD_B_LO = 8'd14;
  localparam logic [7:0] CMD_RD_B_HI = 8'd17;
  localparam logic [7:0] CMD_WR_B_LO = 8'd18;
  localparam logic [7:0] CMD_WR_B_HI = 8'd21;
  localparam logic [7:0] CMD_RD_C    = 8'd22;
  localparam logic [7:0] CMD_WR_C    = 8'd23;
  localparam logic [7:0] CMD_RD_D    = 8'd24;
  localparam logic [7:0] CMD_WR_D    = 8'd25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ARG,
    ST_RSP
`ifdef PCA_RSP_TIMEOUT_EN
    , ST_RERR
`endif
  } pca_state_e;

  typedef struct packed {
    logic n_arg;
    logic n_rsp;
  } cmd_shape_t;

  function automatic cmd_shape_t cmd_shape(input logic [7:0] opcode);
    cmd_shape_t shape;
    shape = '0;
    if ((opcode >= CMD_RD_A_LO && opcode <= CMD_RD_A_HI) ||
        (opcode >= CMD_RD_B_LO && opcode <= CMD_RD_B_HI) ||
        opcode == CMD_RD_C || opcode == CMD_RD_D) begin
      shape.n_rsp = 1'b1;
    end else if ((opcode >= CMD_WR_A_LO && opcode <= CMD_WR_A_HI) ||
                 (opcode >= CMD_WR_B_LO && opcode <= CMD_WR_B_HI) ||
                 opcode == CMD_WR_C || opcode == CMD_WR_D) begin
      shape.n_arg = 1'b1;
    end
    return shape;
  endfunction

endpackage

// File: rtl/probe_cmd_decode.sv
// Combinational opcode decoder: reports operand and response byte counts for a probe command.
module probe_cmd_decode
  import probe_cmd_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic       n_arg_o,
  output logic       n_rsp_o
);

  cmd_shape_t shape;

  always_comb begin
    shape   = cmd_shape(opcode_i);
    n_arg_o = shape.n_arg;
    n_rsp_o = shape.n_rsp;
  end

endmodule

// File: rtl/probe_cmd_arbiter.sv
// Round-robin arbiter giving two command sources whole-command access to the uartprobe byte port.
// Define PCA_RSP_TIMEOUT_EN to bound the response wait (TIMEOUT_CYCLES) and return 8'hFF on expiry.
module probe_cmd_arbiter
  import probe_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       m_areset,
  input  logic       s0_rx_valid,
  input  logic [7:0] s0_rx_data,
  output logic       s0_rx_ready,
  output logic       s0_tx_valid,
  output logic [7:0] s0_tx_data,
  input  logic       s0_tx_ready,
  input  logic       s1_rx_valid,
  input  logic [7:0] s1_rx_data,
  output logic       s1_rx_ready,
  output logic       s1_tx_valid,
  output logic [7:0] s1_tx_data,
  input  logic       s1_tx_ready,
  output logic       m_rx_valid,
  output logic [7:0] m_rx_data,
  input  logic       m_rx_ready,
  input  logic       m_tx_valid,
  input  logic [7:0] m_tx_data,
  output logic       m_tx_ready,
  output logic       owner,
  output logic       busy,
  output logic       stray,
  output logic       timeout
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("probe_cmd_arbiter: TIMEOUT_CYCLES must be nonzero");
  end

  pca_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rsp_pend_q, rsp_pend_d;
  logic       stray_q, stray_d;

  logic       own_rx_valid;
  logic [7:0] own_rx_data;
  logic       own_tx_ready;
  logic       dec_arg, dec_rsp;
  logic       fwd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  always_comb begin
    own_rx_valid = owner_q ? s1_rx_valid : s0_rx_valid;
    own_rx_data  = owner_q ? s1_rx_data  : s0_rx_data;
    own_tx_ready = owner_q ? s1_tx_ready : s0_tx_ready;
  end

  probe_cmd_decode u_decode (
    .opcode_i (own_rx_data),
    .n_arg_o  (dec_arg),
    .n_rsp_o  (dec_rsp)
  );

`ifdef PCA_RSP_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  logic             timeout_q;

  // Counts only starved cycles; a presented-but-unaccepted byte holds the count.
  always_comb begin
    tmo_hit   = (state_q == ST_RSP) && !m_tx_valid && (tmo_cnt_q == TMO_LAST);
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ST_RSP) begin
      tmo_cnt_d = '0;
    end else if (!m_tx_valid) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= tmo_hit;
    end
  end

  always_comb timeout = timeout_q;
`else
  always_comb timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rsp_pend_d = rsp_pend_q;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    m_tx_ready = 1'b1;
    fwd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (s0_rx_valid || s1_rx_valid) begin
          state_d = ST_OPC;
          owner_d = (s0_rx_valid && s1_rx_valid) ? ~owner_q : s1_rx_valid;
        end
      end
      ST_OPC: begin
        m_rx_valid = own_rx_valid;
        m_rx_data  = own_rx_data;
        fwd_ready  = m_rx_ready;
        if (own_rx_valid && m_rx_ready) begin
          rsp_pend_d = dec_rsp;
          if (dec_arg)      state_d = ST_ARG;
          else if (dec_rsp) state_d = ST_RSP;
          else              state_d = ST_IDLE;
        end
      end
      ST_ARG: begin
        m_rx_valid = own_rx_valid;
        m_rx_data  = own_rx_data;
        fwd_ready  = m_rx_ready;
        if (own_rx_valid && m_rx_ready) begin
          state_d = rsp_pend_q ? ST_RSP : ST_IDLE;
        end
      end
      ST_RSP: begin
        m_tx_ready = own_tx_ready;
        rsp_valid  = m_tx_valid;
        rsp_data   = m_tx_data;
        if (m_tx_valid && own_tx_ready) begin
          state_d = ST_IDLE;
        end
`ifdef PCA_RSP_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ST_RERR;
        end
`endif
      end
`ifdef PCA_RSP_TIMEOUT_EN
      ST_RERR: begin
        rsp_valid = 1'b1;
        rsp_data  = 8'hFF;
        if (own_tx_ready) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    s0_rx_ready = fwd_ready & ~owner_q;
    s1_rx_ready = fwd_ready &  owner_q;
    s0_tx_valid = rsp_valid & ~owner_q;
    s1_tx_valid = rsp_valid &  owner_q;
    s0_tx_data  = owner_q ? 8'h00 : rsp_data;
    s1_tx_data  = owner_q ? rsp_data : 8'h00;

    // Outside RSP the probe port is always ready, so any presented byte is discarded.
    stray_d = m_tx_valid && (state_q != ST_RSP);
  end

  always_ff @(posedge clk or posedge m_areset) begin
    if (m_areset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b1;
      rsp_pend_q <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rsp_pend_q <= rsp_pend_d;
      stray_q    <= stray_d;
    end
  end

  always_comb begin
    owner = owner_q;
    busy  = (state_q != ST_IDLE);
    stray = stray_q;
  end

endmodule
